// File: rtl/trap_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// trap_seq_ctrl_if
//   Bundles every non-clock/reset signal of trap_seq_ctrl.
//
//   Port summary (names seen from the controller):
//     inst_i / inst_addr_i             instruction in execute and its PC
//     jump_flag_i / jump_addr_i        branch taken by exu this cycle + target
//     hold_flag_i                      stall from another source
//     int_req_i / global_int_en_i      level interrupt request, mstatus.MIE
//     csr_mtvec_i/mepc_i/mstatus_i     current CSR values
//     csr_we_o/csr_waddr_o/csr_data_o  CSR write port (one CSR per cycle)
//     hold_flag_o                      stall request to the pipeline
//     int_assert_o / int_addr_o        one-cycle redirect strobe and target
//     dbg_state_o/dbg_pc_o/dbg_cause_o FSM state and latched trap PC/cause
//
//   modport slave  : the controller
//   modport master : whoever drives the controller (pipeline / bench)
// ---------------------------------------------------------------------------
interface trap_seq_ctrl_if;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        int_req_i;
    logic        global_int_en_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;

    logic        csr_we_o;
    logic [31:0] csr_waddr_o;
    logic [31:0] csr_data_o;
    logic        hold_flag_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    logic [2:0]  dbg_state_o;
    logic [31:0] dbg_pc_o;
    logic [31:0] dbg_cause_o;

    modport slave (
        input  inst_i, inst_addr_i, jump_flag_i, jump_addr_i, hold_flag_i,
        input  int_req_i, global_int_en_i,
        input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output csr_we_o, csr_waddr_o, csr_data_o,
        output hold_flag_o, int_assert_o, int_addr_o,
        output dbg_state_o, dbg_pc_o, dbg_cause_o
    );

    modport master (
        output inst_i, inst_addr_i, jump_flag_i, jump_addr_i, hold_flag_i,
        output int_req_i, global_int_en_i,
        output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  csr_we_o, csr_waddr_o, csr_data_o,
        input  hold_flag_o, int_assert_o, int_addr_o,
        input  dbg_state_o, dbg_pc_o, dbg_cause_o
    );
endinterface

// File: rtl/trap_seq_ctrl.sv
// ---------------------------------------------------------------------------
// trap_seq_ctrl
//   Trap / interrupt / mret sequencer. On ecall, ebreak or an enabled
//   interrupt it writes mepc, mstatus and mcause (one CSR per cycle) and then
//   redirects the pipeline to mtvec. On mret it restores mstatus and
//   redirects to mepc.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   trap_seq_ctrl_if.slave (see interface header for signal list)
//
//   Handshake semantics: there is no back-pressure. csr_we_o is a strobe;
//   the CSR file must accept csr_waddr_o/csr_data_o on every cycle it is
//   high. int_assert_o is a one-cycle strobe and int_addr_o is meaningful
//   only in that cycle. Both address/data buses are forced to zero whenever
//   their strobe is low. hold_flag_o stalls the pipeline from the detection
//   cycle until the redirect cycle inclusive.
// ---------------------------------------------------------------------------
module trap_seq_ctrl #(
    parameter logic [11:0] CSR_MSTATUS_A = 12'h300,
    parameter logic [11:0] CSR_MEPC_A    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE_A  = 12'h342
) (
    input logic             clk,
    input logic             rst,
    trap_seq_ctrl_if.slave  bus
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_EXTINT = 32'h8000_000B;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MSTATUS = 3'd2,
        W_MCAUSE  = 3'd3,
        JUMP      = 3'd4,
        R_MSTATUS = 3'd5,
        R_JUMP    = 3'd6
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic        r_csr_we;
    logic [11:0] r_csr_waddr;
    logic [31:0] r_csr_data;
    logic        r_int_assert;
    logic [31:0] r_int_addr;

    logic        w_ecall;
    logic        w_ebreak;
    logic        w_int;
    logic        w_mret;
    logic        w_detect;
    logic [31:0] w_int_pc;
    logic [31:0] w_mstatus_trap;
    logic [31:0] w_mstatus_mret;

    assign w_ecall  = (bus.inst_i == INST_ECALL);
    assign w_ebreak = (bus.inst_i == INST_EBREAK);
    assign w_int    = bus.int_req_i & bus.global_int_en_i & ~bus.hold_flag_i;
    assign w_mret   = (bus.inst_i == INST_MRET);
    assign w_detect = (r_state == IDLE) & (w_ecall | w_ebreak | w_int | w_mret);

    // An interrupt taken while a branch resolves must return to the branch
    // target, not to the instruction that was being squashed.
    assign w_int_pc = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;

    // Trap entry: MPIE <= MIE, MIE <= 0.
    assign w_mstatus_trap = {bus.csr_mstatus_i[31:8], bus.csr_mstatus_i[3],
                             bus.csr_mstatus_i[6:4], 1'b0,
                             bus.csr_mstatus_i[2:0]};
    // mret: MIE <= MPIE, MPIE <= 1.
    assign w_mstatus_mret = {bus.csr_mstatus_i[31:8], 1'b1,
                             bus.csr_mstatus_i[6:4], bus.csr_mstatus_i[7],
                             bus.csr_mstatus_i[2:0]};

    // Outputs are registered: the values for a state are loaded on the same
    // edge that enters it, so they line up exactly with r_state and are
    // cleared asynchronously together with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pc         <= 32'd0;
            r_cause      <= 32'd0;
            r_csr_we     <= 1'b0;
            r_csr_waddr  <= 12'd0;
            r_csr_data   <= 32'd0;
            r_int_assert <= 1'b0;
            r_int_addr   <= 32'd0;
        end else begin
            r_csr_we     <= 1'b0;
            r_csr_waddr  <= 12'd0;
            r_csr_data   <= 32'd0;
            r_int_assert <= 1'b0;
            r_int_addr   <= 32'd0;

            case (r_state)
                IDLE: begin
                    if (w_ecall || w_ebreak) begin
                        r_state     <= W_MEPC;
                        r_pc        <= bus.inst_addr_i;
                        r_cause     <= w_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                        r_csr_we    <= 1'b1;
                        r_csr_waddr <= CSR_MEPC_A;
                        r_csr_data  <= bus.inst_addr_i;
                    end else if (w_int) begin
                        r_state     <= W_MEPC;
                        r_pc        <= w_int_pc;
                        r_cause     <= CAUSE_EXTINT;
                        r_csr_we    <= 1'b1;
                        r_csr_waddr <= CSR_MEPC_A;
                        r_csr_data  <= w_int_pc;
                    end else if (w_mret) begin
                        r_state     <= R_MSTATUS;
                        r_csr_we    <= 1'b1;
                        r_csr_waddr <= CSR_MSTATUS_A;
                        r_csr_data  <= w_mstatus_mret;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                W_MEPC: begin
                    r_state     <= W_MSTATUS;
                    r_csr_we    <= 1'b1;
                    r_csr_waddr <= CSR_MSTATUS_A;
                    r_csr_data  <= w_mstatus_trap;
                end

                W_MSTATUS: begin
                    r_state     <= W_MCAUSE;
                    r_csr_we    <= 1'b1;
                    r_csr_waddr <= CSR_MCAUSE_A;
                    r_csr_data  <= r_cause;
                end

                W_MCAUSE: begin
                    r_state      <= JUMP;
                    r_int_assert <= 1'b1;
                    r_int_addr   <= bus.csr_mtvec_i;
                end

                JUMP: begin
                    r_state <= IDLE;
                end

                R_MSTATUS: begin
                    r_state      <= R_JUMP;
                    r_int_assert <= 1'b1;
                    r_int_addr   <= bus.csr_mepc_i;
                end

                R_JUMP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.csr_we_o     = r_csr_we;
    assign bus.csr_waddr_o  = {20'd0, r_csr_waddr};
    assign bus.csr_data_o   = r_csr_data;
    assign bus.int_assert_o = r_int_assert;
    assign bus.int_addr_o   = r_int_addr;

    // Stall must already be asserted in the cycle the request is seen, so
    // this one is combinational; rst gates it because inputs may still
    // present a request while the block is held in reset.
    assign bus.hold_flag_o  = ~rst & (w_detect | (r_state != IDLE));

    assign bus.dbg_state_o  = r_state;
    assign bus.dbg_pc_o     = r_pc;
    assign bus.dbg_cause_o  = r_cause;

endmodule

// File: doc/trap_seq_ctrl.md
TRAP_SEQ_CTRL -- requirements
Module: trap_seq_ctrl

Interface
REQ-001 Parameter CSR_MSTATUS_A, 12'h300, mstatus CSR address driven on csr_waddr_o[11:0].
REQ-002 Parameter CSR_MEPC_A, 12'h341, mepc CSR address.
REQ-003 Parameter CSR_MCAUSE_A, 12'h342, mcause CSR address.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 inst_i  in  32  instruction in execute stage.
REQ-007 inst_addr_i  in  32  PC of inst_i.
REQ-008 jump_flag_i / jump_addr_i  in  1 / 32  branch taken by exu this cycle, and its target.
REQ-009 hold_flag_i  in  1  pipeline stalled by another source.
REQ-010 int_req_i  in  1  external interrupt request, level.
REQ-011 global_int_en_i  in  1  mstatus.MIE from CSR file.
REQ-012 csr_mtvec_i / csr_mepc_i / csr_mstatus_i  in  32 each  current CSR values.
REQ-013 csr_we_o  out  1  CSR write strobe on the CSR file's controller port.
REQ-014 csr_waddr_o  out  32  CSR write address, upper 20 bits zero.
REQ-015 csr_data_o  out  32  CSR write data.
REQ-016 hold_flag_o  out  1  stall request to pipeline.
REQ-017 int_assert_o  out  1  one-cycle redirect strobe.
REQ-018 int_addr_o  out  32  redirect target, valid while int_assert_o=1.

Function
REQ-019 The FSM SHALL use states IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, JUMP, R_MSTATUS, R_JUMP.
REQ-020 In IDLE, detection priority SHALL be: inst_i==32'h00000073 (ecall) or 32'h00100073 (ebreak), then interrupt (int_req_i & global_int_en_i & ~hold_flag_i), then inst_i==32'h30200073 (mret).
REQ-021 On detection the block SHALL latch trap PC and cause in the same edge and move to W_MEPC (trap) or R_MSTATUS (mret).
REQ-022 Latched PC SHALL be inst_addr_i for ecall/ebreak; for interrupt, jump_addr_i if jump_flag_i else inst_addr_i.
REQ-023 Latched cause SHALL be 32'd11 ecall, 32'd3 ebreak, 32'h8000000B interrupt.
REQ-024 hold_flag_o SHALL be high combinationally in the detection cycle and in every non-IDLE state; low otherwise.
REQ-025 W_MEPC: csr_we_o=1, address MEPC, data latched PC; next W_MSTATUS.
REQ-026 W_MSTATUS: csr_we_o=1, address MSTATUS, data = csr_mstatus_i with bit7 (MPIE) = bit3, bit3 (MIE) = 0; next W_MCAUSE.
REQ-027 W_MCAUSE: csr_we_o=1, address MCAUSE, data latched cause; next JUMP.
REQ-028 JUMP: int_assert_o=1, int_addr_o=csr_mtvec_i; next IDLE.
REQ-029 R_MSTATUS: csr_we_o=1, address MSTATUS, data = csr_mstatus_i with bit3 = bit7, bit7 = 1; next R_JUMP.
REQ-030 R_JUMP: int_assert_o=1, int_addr_o=csr_mepc_i; next IDLE.
REQ-031 Trap latency: detection to int_assert_o SHALL be exactly 4 cycles; mret: exactly 2 cycles.
REQ-032 csr_we_o SHALL be high only in W_* and R_MSTATUS states, one CSR per cycle; csr_waddr_o/csr_data_o SHALL be 0 when csr_we_o=0.
REQ-033 int_addr_o SHALL be 0 when int_assert_o=0.
REQ-034 Requests arriving in any non-IDLE state SHALL be ignored; int_req_i still high on return to IDLE SHALL be re-evaluated (with updated global_int_en_i).
REQ-035 ecall/ebreak SHALL be accepted regardless of hold_flag_i and global_int_en_i.
REQ-036 Simultaneous ecall and int_req_i SHALL take ecall only; interrupt pends as level.

Reset
REQ-037 rst=1 SHALL force IDLE and clear latched PC/cause immediately, asynchronously, including mid-sequence; no further CSR writes of an aborted sequence.
REQ-038 During reset all outputs SHALL be 0.

Verification
REQ-039 ecall at PC 0x100, mstatus=0x8, mtvec=0x200 -> writes mepc=0x100, mstatus=0x80, mcause=11 on cycles 1-3; int_assert_o with 0x200 cycle 4; hold high cycles 0-4.
REQ-040 int_req_i=1, MIE=1, jump_flag_i=1, jump_addr_i=0x3C -> mepc=0x3C, mcause=0x8000000B, redirect to mtvec.
REQ-041 mret with mstatus=0x80, mepc=0x104 -> mstatus write 0x88 cycle 1; int_assert_o, int_addr_o=0x104 cycle 2.
REQ-042 int_req_i=1 with MIE=0, or with hold_flag_i=1 -> no csr_we_o, no hold_flag_o.
REQ-043 ecall and int_req_i same cycle -> mcause=11; after JUMP with MIE now 0, interrupt not taken.
REQ-044 rst pulsed during W_MSTATUS -> outputs 0 immediately; after release IDLE, no mcause write.
